// File: rtl/buffer_mem.sv
// Simple dual-port RAM buffer with a registered read port and per-entry written flags.
// Optional define BUFFER_WRITE_FIRST_EN forwards a same-edge write to a same-address read.
module buffer_mem #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          write_enable,
  input  logic [AW-1:0] write_addr,
  input  logic [DW-1:0] write_data,
  input  logic          read_enable,
  input  logic [AW-1:0] read_addr,
  output logic [DW-1:0] read_data,
  output logic          read_valid
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [DW-1:0]    rd_next;

  // The array is not reset. A write landing while reset_n is low is harmless,
  // because its written flag is held clear and the entry reads back as zero.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
  end

  always_comb begin
    rd_next = written[read_addr] ? mem[read_addr] : '0;
`ifdef BUFFER_WRITE_FIRST_EN
    if (write_enable && (write_addr == read_addr)) begin
      rd_next = write_data;
    end
`endif
  end

  // Handshake: read_valid is a one-cycle pulse following each edge that sampled
  // read_enable=1; read_data is then the fresh word and otherwise holds its value.
  // There is no back-pressure, so the consumer must take the word on that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      written    <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      if (write_enable) begin
        written[write_addr] <= 1'b1;
      end
      read_valid <= read_enable;
      if (read_enable) begin
        read_data <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_buffer_mem.sv
// Directed bench for buffer_mem: a driver issues write/read cycles, pushing expected
// read words into exp_q; a negedge monitor pops and compares on every read_valid.
module tb_buffer_mem;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clock;
  logic          reset_n;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          read_valid;

  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int reads_issued = 0;
  int valids_seen = 0;

  buffer_mem #(.AW(AW), .DW(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_valid   (read_valid)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
    end
  endtask

  // driver: present one cycle's inputs, let one rising edge sample them, then idle
  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra, input logic [DW-1:0] exp_rd);
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_enable  = re;
    read_addr    = ra;
    if (re) begin
      exp_q.push_back(exp_rd);
      reads_issued++;
    end
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc(1'b1, a, d, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    cyc(1'b0, '0, '0, 1'b1, a, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clock);
      if (read_valid === 1'b1) begin
        valids_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got read_valid=1 data 0x%02h, expected no read", read_data);
        end else begin
          check("read_data", read_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] same_edge_exp;
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    read_enable  = 1'b0;
    read_addr    = '0;
    reset_n      = 1'b0;
    #2;
    check("reset_read_data", read_data, 8'h00);
    check("reset_read_valid", {7'b0, read_valid}, 8'h00);
    #20;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    wr(8'h00, 8'hF1);
    rd(8'h00, 8'hF1);
    // write_data toggles with write_enable low: storage untouched
    cyc(1'b0, 8'h00, 8'hEE, 1'b0, '0, '0);
    rd(8'h00, 8'hF1);
    idle(1);
    check("hold_no_read", read_data, 8'hF1);
    check("valid_low_no_read", {7'b0, read_valid}, 8'h00);

    wr(8'h00, 8'hEE);
    check("write_no_read_change", read_data, 8'hF1);
    rd(8'h00, 8'hEE);

    rd(8'h55, 8'h00);
    wr(8'h55, 8'hA5);
    rd(8'h55, 8'hA5);

    wr(8'h07, 8'h11);
`ifdef BUFFER_WRITE_FIRST_EN
    same_edge_exp = 8'h3C;
`else
    same_edge_exp = 8'h11;
`endif
    cyc(1'b1, 8'h07, 8'h3C, 1'b1, 8'h07, same_edge_exp);
    rd(8'h07, 8'h3C);

    // same-edge write and read to different addresses
    cyc(1'b1, 8'h09, 8'h22, 1'b1, 8'h55, 8'hA5);
    wr(8'hFF, 8'h77);
    // back-to-back reads, including the top address
    rd(8'h00, 8'hEE);
    rd(8'h07, 8'h3C);
    rd(8'h09, 8'h22);
    rd(8'hFF, 8'h77);
    rd(8'h55, 8'hA5);
    idle(2);

    // asynchronous reset mid-cycle, away from any edge
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_read_data", read_data, 8'h00);
    check("async_reset_read_valid", {7'b0, read_valid}, 8'h00);
    write_enable = 1'b1;
    write_addr   = 8'h03;
    write_data   = 8'h99;
    read_enable  = 1'b1;
    read_addr    = 8'h00;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("reset_ignores_read", {7'b0, read_valid}, 8'h00);
    check("reset_hold_data", read_data, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    rd(8'h00, 8'h00);
    rd(8'h07, 8'h00);
    rd(8'h03, 8'h00);
    rd(8'hFF, 8'h00);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending entries expected 0", exp_q.size());
    end
    checks++;
    if (valids_seen != reads_issued) begin
      errors++;
      $display("FAIL valid_count: got %0d pulses expected %0d", valids_seen, reads_issued);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_mem.md
# buffer_mem

Single-clock simple dual-port RAM buffer: one synchronous write port, one synchronous read port with a registered output. It stores captured data words, such as sniffed bus cycles, until a consumer reads them back. Each entry carries a written-since-reset flag, so stale contents are never returned after reset.

## Interface
- AW, default 8: address width; depth = 2^AW entries.
- DW, default 8: data word width.

- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- write_enable  input  1  write strobe, sampled at rising edge.
- write_addr  input  AW  write address.
- write_data  input  DW  write data.
- read_enable  input  1  read strobe, sampled at rising edge.
- read_addr  input  AW  read address.
- read_data  output  DW  registered read data.
- read_valid  output  1  one-cycle pulse: read_data was updated by the previous edge's read.

## Operation
- Storage: 2^AW x DW array plus a 2^AW-bit written flag vector.
- Write: at a rising edge with write_enable=1, mem[write_addr] <= write_data and written[write_addr] <= 1.
- write_data/write_addr changes without a qualifying edge have no effect on storage.
- Read: at a rising edge with read_enable=1:
  - read_data <= mem[read_addr] if written[read_addr], else 0.
  - read_valid <= 1.
- No read: read_data holds its value; read_valid <= 0.
- A write never changes read_data directly. A new value appears only after a later read.
- Addresses wrap naturally: the full AW range is valid and there are no out-of-range cases.
- Reset (reset_n=0, asynchronous):
  - read_data = 0, read_valid = 0.
  - All written flags cleared.
  - Array contents are not cleared; the flags mask them.
- While reset_n=0: writes and reads are ignored.
- Reset release: the first qualifying edge after reset_n rises performs normal operation.

## Timing
- Write latency: data is readable by a read on the edge after the write edge.
- Read latency: 1 cycle. read_data and read_valid are valid after the edge that sampled read_enable.
- Simultaneous write and read to the same address on one edge: see Configuration.
- Simultaneous write and read to different addresses: both take effect and are independent.
- Back-to-back reads every cycle: read_valid stays high, and read_data updates each cycle.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge. A write or read in flight on that edge is discarded.

## Configuration
- BUFFER_WRITE_FIRST_EN
  - Defined: a same-edge write and read to the same address returns the new write_data (bypass forwarding), and the written flag is treated as set.
  - Undefined (default): read-first. The same-edge read returns the previous contents, or 0 if the entry was unwritten; the new data is visible from the next read.

## Test plan
- After reset, write 0xF1 to addr 0, then read addr 0 → read_data=0xF1 one edge later, with a read_valid pulse.
- Change write_data to 0xEE with write_enable=0, then read addr 0 → read_data stays 0xF1.
- Write 0xEE to addr 0 with read_enable=0 → read_data holds 0xF1. A following read → 0xEE.
- Read the unwritten addr 0x55 after reset → read_data=0x00. Then write 0xA5 there and read again → 0xA5.
- Same edge: write 0x3C and read addr 7, which holds 0x11 → read_data=0x11 in the default build, 0x3C with BUFFER_WRITE_FIRST_EN.
- Assert reset_n mid-stream after data written → read_data=0 and read_valid=0 immediately. Reads of previously written addresses return 0 after release.
